// File: rtl/store_buffer.sv
// Store buffer: queues formatted stores in a circular FIFO and retires them in
// order to data memory as word-aligned, lane-shifted writes with byte enables.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [2:0]              st_funct3,
  input  logic [31:0]             st_addr,
  input  logic [31:0]             st_data,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [31:0]             mem_wr_addr,
  output logic [31:0]             mem_wr_data,
  output logic [3:0]              mem_wr_be,
  output logic                    misaligned,
  output logic                    buf_empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misaligned_q, misaligned_d;

  // Storage array is deliberately left unreset; outputs only matter while valid.
  logic [31:0] addrMem [DEPTH];
  logic [31:0] dataMem [DEPTH];
  logic [3:0]  beMem   [DEPTH];

  logic        accept;
  logic        enq;
  logic        deq;
  logic        isSb, isSh, isSw;
  logic        badAlign;
  logic [31:0] addrNew;
  logic [31:0] dataNew;
  logic [3:0]  beNew;

  assign st_ready     = (count_q < CW'(DEPTH));
  assign mem_wr_valid = (count_q != '0);
  assign buf_empty    = (count_q == '0);
  assign mem_wr_addr  = addrMem[rdPtr_q];
  assign mem_wr_data  = dataMem[rdPtr_q];
  assign mem_wr_be    = beMem[rdPtr_q];
  assign misaligned   = misaligned_q;
  assign count        = count_q;

  always_comb begin
    isSb     = (st_funct3 == F3_SB);
    isSh     = (st_funct3 == F3_SH);
    isSw     = (st_funct3 == F3_SW);
    accept   = st_valid && st_ready;
    badAlign = (isSh && st_addr[0]) || (isSw && (st_addr[1:0] != 2'b00));
    enq      = accept && (isSb || isSh || isSw) && !badAlign;
    deq      = mem_wr_valid && mem_wr_ready;
    addrNew  = {st_addr[31:2], 2'b00};
    dataNew  = st_data << {st_addr[1:0], 3'b000};
    beNew    = 4'b1111;
    if (isSb) beNew = 4'b0001 << st_addr[1:0];
    if (isSh) beNew = 4'b0011 << st_addr[1:0];
  end

  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    misaligned_d = accept && badAlign;
    if (enq) wrPtr_d = wrPtr_q + 1'b1;
    if (deq) rdPtr_d = rdPtr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addrMem[wrPtr_q] <= addrNew;
      dataMem[wrPtr_q] <= dataNew;
      beMem[wrPtr_q]   <= beNew;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drives stores on the falling edge and checks
// hand-computed memory writes, flags and occupancy before the next rising edge.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        misaligned;
  logic        buf_empty;
  logic [2:0]  count;

  int vectors = 0;
  int errors  = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
    .st_addr(st_addr), .st_data(st_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be),
    .misaligned(misaligned), .buf_empty(buf_empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full clock: inputs change and outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] d);
    st_valid  = v;
    st_funct3 = f;
    st_addr   = a;
    st_data   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    mem_wr_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", buf_empty); end
    vectors++;
    if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_wr_valid); end
    vectors++;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", st_ready); end
    vectors++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
  endtask

  task automatic test_byte_store();
    mem_wr_ready = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    step();
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    vectors++;
    if (mem_wr_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b expected 1", mem_wr_valid); end
    vectors++;
    if (mem_wr_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", mem_wr_addr); end
    vectors++;
    if (mem_wr_data !== 32'hAB00_0000) begin errors++; $display("FAIL sb_data: got %h expected ab000000", mem_wr_data); end
    vectors++;
    if (mem_wr_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", mem_wr_be); end
    step();
    vectors++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL sb_drained: got %b expected 1", buf_empty); end
  endtask

  task automatic test_half_word_store();
    mem_wr_ready = 1'b1;
    applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
    step();
    applyStimulus(1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    vectors++;
    if (mem_wr_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h expected 00002000", mem_wr_addr); end
    vectors++;
    if (mem_wr_data !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_data: got %h expected beef0000", mem_wr_data); end
    vectors++;
    if (mem_wr_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", mem_wr_be); end
    step();
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    vectors++;
    if (mem_wr_addr !== 32'h0000_3000) begin errors++; $display("FAIL sw_addr: got %h expected 00003000", mem_wr_addr); end
    vectors++;
    if (mem_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data: got %h expected deadbeef", mem_wr_data); end
    vectors++;
    if (mem_wr_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", mem_wr_be); end
    step();
    vectors++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL sw_drained: got %b expected 1", buf_empty); end
  endtask

  task automatic test_misaligned();
    mem_wr_ready = 1'b1;
    applyStimulus(1'b1, 3'b001, 32'h0000_2001, 32'h0000_1234);
    step();
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    vectors++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh_pulse: got %b expected 1", misaligned); end
    vectors++;
    if (count !== 3'd0) begin errors++; $display("FAIL mis_sh_count: got %0d expected 0", count); end
    vectors++;
    if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL mis_sh_valid: got %b expected 0", mem_wr_valid); end
    step();
    vectors++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_sh_clear: got %b expected 0", misaligned); end
    applyStimulus(1'b1, 3'b010, 32'h0000_3002, 32'h1234_5678);
    step();
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    vectors++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sw_pulse: got %b expected 1", misaligned); end
    vectors++;
    if (count !== 3'd0) begin errors++; $display("FAIL mis_sw_count: got %0d expected 0", count); end
    vectors++;
    if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL mis_sw_valid: got %b expected 0", mem_wr_valid); end
    step();
    vectors++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_sw_clear: got %b expected 0", misaligned); end
    // Unsupported width code is swallowed silently.
    applyStimulus(1'b1, 3'b011, 32'h0000_4001, 32'h1111_1111);
    step();
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    vectors++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL bad_f3_pulse: got %b expected 0", misaligned); end
    vectors++;
    if (count !== 3'd0) begin errors++; $display("FAIL bad_f3_count: got %0d expected 0", count); end
  endtask

  task automatic test_full_stall();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'b010, 32'h0000_4000 + 32'(4 * i), 32'h0000_1000 + 32'(i));
      step();
    end
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    vectors++;
    if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
    vectors++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", st_ready); end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (mem_wr_addr !== 32'h0000_4000 || mem_wr_data !== 32'h0000_1000 || mem_wr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b a=%h d=%h expected v=1 a=00004000 d=00001000",
                 c, mem_wr_valid, mem_wr_addr, mem_wr_data);
      end
      step();
    end
    mem_wr_ready = 1'b1;
    vectors++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b expected 0", st_ready); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem_wr_addr !== 32'h0000_4000 + 32'(4 * i) || mem_wr_data !== 32'h0000_1000 + 32'(i)) begin
        errors++;
        $display("FAIL drain_order%0d: got a=%h d=%h expected a=%h d=%h", i, mem_wr_addr, mem_wr_data,
                 32'h0000_4000 + 32'(4 * i), 32'h0000_1000 + 32'(i));
      end
      step();
    end
    vectors++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", buf_empty); end
    vectors++;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b expected 1", st_ready); end
  endtask

  task automatic test_back_to_back();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 3'b010, 32'h0000_5000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
      step();
    end
    vectors++;
    if (count !== 3'd2) begin errors++; $display("FAIL b2b_fill: got %0d expected 2", count); end
    mem_wr_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      applyStimulus(1'b1, 3'b010, 32'h0000_5000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
      step();
      vectors++;
      if (count !== 3'd2 || mem_wr_addr !== 32'h0000_5000 + 32'(4 * (i - 1))
          || mem_wr_data !== 32'h0000_00A0 + 32'(i - 1)) begin
        errors++;
        $display("FAIL b2b_step%0d: got cnt=%0d a=%h d=%h expected cnt=2 a=%h d=%h", i, count,
                 mem_wr_addr, mem_wr_data, 32'h0000_5000 + 32'(4 * (i - 1)), 32'h0000_00A0 + 32'(i - 1));
      end
    end
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    vectors++;
    if (mem_wr_addr !== 32'h0000_5014 || count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_tail: got a=%h cnt=%0d expected a=00005014 cnt=1", mem_wr_addr, count);
    end
    step();
    vectors++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", buf_empty); end
  endtask

  task automatic test_reset_mid();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'b010, 32'h0000_6000 + 32'(4 * i), 32'h0000_0C00 + 32'(i));
      step();
    end
    vectors++;
    if (count !== 3'd3) begin errors++; $display("FAIL mid_fill: got %0d expected 3", count); end
    // Reset wins over a store presented in the same cycle.
    rst = 1'b1;
    applyStimulus(1'b1, 3'b010, 32'h0000_7000, 32'h0000_0DDD);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    mem_wr_ready = 1'b1;
    vectors++;
    if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
    vectors++;
    if (buf_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", buf_empty); end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL mid_no_write%0d: got %b expected 0", c, mem_wr_valid); end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_wr_ready = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_byte_store();
    test_half_word_store();
    test_misaligned();
    test_full_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
